// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath enable and mux select. It also handles the shared memory handshake,
// counts retired instructions, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic [2:0]  imm_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [3:0]  alu_op,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        trap,
   output logic [2:0]  state_o,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Wait-counter value at which one more idle cycle means the memory has timed out.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] instret_q, instret_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_r, is_i, is_load, is_store, is_branch;
   logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
   logic [2:0] imm_dec;
   logic [3:0] alu_dec;

   logic       mem_req_c, mem_we_c, mem_addr_sel_c, ir_we_c, pc_we_c, pc_sel_c;
   logic [2:0] imm_sel_c;
   logic       alu_a_sel_c, alu_b_sel_c, reg_we_c, trap_c;
   logic [3:0] alu_op_c;
   logic [1:0] wb_sel_c;

   logic unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                      is_jal | is_jalr | is_lui | is_auipc;

   // Immediate format and ALU operation decoded from the current IR.
   always_comb begin
      imm_dec = 3'd0;
      alu_dec = 4'b0000;
      if (is_store) begin
         imm_dec = 3'd1;
      end else if (is_branch) begin
         imm_dec = 3'd2;
      end else if (is_lui || is_auipc) begin
         imm_dec = 3'd3;
      end else if (is_jal) begin
         imm_dec = 3'd4;
      end
      if (is_r) begin
         alu_dec = {instr[30], funct3};
      end else if (is_i) begin
         alu_dec = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
      end else if (is_lui) begin
         alu_dec = 4'b1111;
      end
   end

   // Next-state and datapath control for the current state.
   always_comb begin
      state_d        = state_q;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_we_c        = 1'b0;
      pc_we_c        = 1'b0;
      pc_sel_c       = 1'b0;
      imm_sel_c      = 3'd0;
      alu_a_sel_c    = 1'b0;
      alu_b_sel_c    = 1'b0;
      alu_op_c       = 4'b0000;
      reg_we_c       = 1'b0;
      wb_sel_c       = 2'd0;
      trap_c         = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_we_c = 1'b1;
               state_d = DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = TRAP;
            end
         end
         DECODE: begin
            imm_sel_c = imm_dec;
            state_d   = is_legal ? EXEC : TRAP;
         end
         EXEC: begin
            imm_sel_c   = imm_dec;
            alu_a_sel_c = is_auipc | is_branch | is_jal;
            alu_b_sel_c = ~is_r;
            alu_op_c    = alu_dec;
            if (is_load || is_store) begin
               state_d = MEM;
            end else if (is_branch) begin
               pc_we_c  = 1'b1;
               pc_sel_c = br_taken;
               state_d  = FETCH;
            end else if (is_jal || is_jalr) begin
               reg_we_c = 1'b1;
               wb_sel_c = 2'd2;
               pc_we_c  = 1'b1;
               pc_sel_c = 1'b1;
               state_d  = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            imm_sel_c      = imm_dec;
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pc_we_c = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = TRAP;
            end
         end
         WB: begin
            imm_sel_c = imm_dec;
            reg_we_c  = 1'b1;
            wb_sel_c  = is_load ? 2'd1 : 2'd0;
            pc_we_c   = 1'b1;
            state_d   = FETCH;
         end
         TRAP: begin
            trap_c = 1'b1;
         end
         default: begin
            state_d = TRAP;
         end
      endcase
   end

   // Wait counter restarts on every state change; instret counts completions back to FETCH.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = 8'd0;
      end else if ((state_q == FETCH || state_q == MEM) && !mem_ready) begin
         wait_d = wait_q + 8'd1;
      end
      instret_d = instret_q;
      if (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) begin
         instret_d = instret_q + 32'd1;
      end
   end

   // State, wait counter and retired count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         wait_q    <= 8'd0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
      end
   end

   assign mem_req      = rst_n & mem_req_c;
   assign mem_we       = rst_n & mem_we_c;
   assign mem_addr_sel = rst_n & mem_addr_sel_c;
   assign ir_we        = rst_n & ir_we_c;
   assign pc_we        = rst_n & pc_we_c;
   assign pc_sel       = rst_n & pc_sel_c;
   assign imm_sel      = rst_n ? imm_sel_c : 3'd0;
   assign alu_a_sel    = rst_n & alu_a_sel_c;
   assign alu_b_sel    = rst_n & alu_b_sel_c;
   assign alu_op       = rst_n ? alu_op_c : 4'd0;
   assign reg_we       = rst_n & reg_we_c;
   assign wb_sel       = rst_n ? wb_sel_c : 2'd0;
   assign trap         = rst_n & trap_c;
   assign state_o      = rst_n ? 3'(state_q) : 3'd0;
   assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed plus randomized instructions checked
// against a per-instruction cycle-script model built from the sequencing rules.
module tb_multicycle_ctrl;

   localparam int MEM_TIMEOUT = 15;
   localparam int TRAP_HOLD   = 22;

   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
   localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        br_taken = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
   logic [2:0]  imm_sel;
   logic        alu_a_sel, alu_b_sel;
   logic [3:0]  alu_op;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [2:0]  state_o;
   logic [31:0] instret;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic [2:0] imm_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic [3:0] alu_op;
      logic       reg_we;
      logic [1:0] wb_sel;
      logic       trap;
   } outs_t;

   typedef struct packed {
      logic        rdy;
      outs_t       o;
      logic [31:0] ir;
   } rec_t;

   outs_t       obs;
   rec_t        exp_q[$];
   logic [31:0] model_instret = 32'd0;
   string       cur_name = "";
   int          checks = 0;
   int          failures = 0;

   assign obs = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                 imm_sel, alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, trap};

   multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
      .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
      .state_o(state_o), .instret(instret)
   );

   always #5 clk = ~clk;

   function automatic int cls_of(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUIPC;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic logic [6:0] legal_op(input int k);
      case (k)
         0: return 7'b0110011;
         1: return 7'b0010011;
         2: return 7'b0000011;
         3: return 7'b0100011;
         4: return 7'b1100011;
         5: return 7'b1101111;
         6: return 7'b1100111;
         7: return 7'b0110111;
         default: return 7'b0010111;
      endcase
   endfunction

   function automatic logic [2:0] imm_of(input int c);
      case (c)
         C_ST: return 3'd1;
         C_BR: return 3'd2;
         C_LUI, C_AUIPC: return 3'd3;
         C_JAL: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] aluop_of(input int c, input logic [31:0] ins);
      case (c)
         C_R: return {ins[30], ins[14:12]};
         C_I: return {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]};
         C_LUI: return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic outs_t trap_outs();
      outs_t o = '0;
      o.state = 3'd5;
      o.trap  = 1'b1;
      return o;
   endfunction

   task automatic push_rec(input logic rdy, input outs_t o);
      rec_t r;
      r.rdy = rdy;
      r.o   = o;
      r.ir  = model_instret;
      exp_q.push_back(r);
   endtask

   task automatic push_trap();
      repeat (TRAP_HOLD) push_rec(1'($urandom_range(0, 1)), trap_outs());
   endtask

   // Idle memory cycles; a run of MEM_TIMEOUT of them ends in TRAP.
   task automatic push_wait(input logic [2:0] st, input logic [2:0] imm, input logic we,
                            input logic asel, input int n, output bit trapped);
      outs_t o = '0;
      int    k;
      o.state        = st;
      o.mem_req      = 1'b1;
      o.mem_addr_sel = asel;
      o.mem_we       = we;
      o.imm_sel      = imm;
      k = (n < MEM_TIMEOUT) ? n : MEM_TIMEOUT;
      repeat (k) push_rec(1'b0, o);
      trapped = (n >= MEM_TIMEOUT);
      if (trapped) push_trap();
   endtask

   // Cycle-by-cycle script of expected outputs for one instruction.
   task automatic buildInstr(input logic [31:0] ins, input logic br, input int fw,
                             input int mw, output bit trapped);
      int         c;
      logic [2:0] imm;
      outs_t      o;
      bit         t;
      c   = cls_of(ins[6:0]);
      imm = imm_of(c);
      trapped = 1'b1;
      push_wait(3'd0, 3'd0, 1'b0, 1'b0, fw, t);
      if (t) return;
      o = '0; o.state = 3'd0; o.mem_req = 1'b1; o.ir_we = 1'b1;
      push_rec(1'b1, o);
      o = '0; o.state = 3'd1; o.imm_sel = imm;
      push_rec(1'($urandom_range(0, 1)), o);
      if (c == C_ILL) begin
         push_trap();
         return;
      end
      o = '0; o.state = 3'd2; o.imm_sel = imm;
      o.alu_a_sel = (c == C_AUIPC || c == C_BR || c == C_JAL);
      o.alu_b_sel = (c != C_R);
      o.alu_op    = aluop_of(c, ins);
      if (c == C_BR) begin
         o.pc_we = 1'b1; o.pc_sel = br;
      end
      if (c == C_JAL || c == C_JALR) begin
         o.reg_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 1'b1;
      end
      push_rec(1'($urandom_range(0, 1)), o);
      if (c == C_LD || c == C_ST) begin
         push_wait(3'd3, imm, (c == C_ST), 1'b1, mw, t);
         if (t) return;
         o = '0; o.state = 3'd3; o.mem_req = 1'b1; o.mem_addr_sel = 1'b1;
         o.mem_we = (c == C_ST); o.imm_sel = imm; o.pc_we = (c == C_ST);
         push_rec(1'b1, o);
      end
      if (c != C_BR && c != C_JAL && c != C_JALR && c != C_ST) begin
         o = '0; o.state = 3'd4; o.imm_sel = imm; o.reg_we = 1'b1;
         o.wb_sel = (c == C_LD) ? 2'd1 : 2'd0; o.pc_we = 1'b1;
         push_rec(1'($urandom_range(0, 1)), o);
      end
      model_instret = model_instret + 32'd1;
      trapped = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input outs_t exp_o, input logic [31:0] exp_ir);
      checks++;
      assert (obs === exp_o) else begin
         failures++;
         $error("[TB] FAIL %s outputs: got %h expected %h", tag, obs, exp_o);
      end
      checks++;
      assert (instret === exp_ir) else begin
         failures++;
         $error("[TB] FAIL %s instret: got %0d expected %0d", tag, instret, exp_ir);
      end
   endtask

   // Plays queued cycles: drive after the rising edge, check on the falling edge.
   task automatic applyStimulus(input int max_cycles);
      int n = 0;
      while (exp_q.size() > 0 && n < max_cycles) begin
         rec_t r = exp_q.pop_front();
         mem_ready = r.rdy;
         @(negedge clk);
         checkOutput($sformatf("%s/c%0d", cur_name, n), r.o, r.ir);
         @(posedge clk);
         #1;
         n++;
      end
      exp_q.delete();
   endtask

   task automatic runInstr(input string name, input logic [31:0] ins, input logic br,
                           input int fw, input int mw, input int max_cycles);
      bit t;
      cur_name = name;
      instr    = ins;
      br_taken = br;
      buildInstr(ins, br, fw, mw, t);
      applyStimulus(max_cycles);
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
      model_instret = 32'd0;
      checkOutput("reset", '0, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] ins;
      $display("[TB] start");
      doReset();

      runInstr("addi", 32'h00700093, 1'b0, 0, 0, 1000);
      runInstr("beq_taken", 32'h00000163, 1'b1, 0, 0, 1000);
      runInstr("beq_not", 32'h00000163, 1'b0, 0, 0, 1000);
      runInstr("sw_wait3", 32'h007001A3, 1'b0, 0, 3, 1000);
      runInstr("addi_fetch14", 32'h00700093, 1'b0, MEM_TIMEOUT - 1, 0, 1000);

      for (int i = 0; i < 40; i++) begin
         ins = $urandom;
         ins[6:0] = legal_op(int'($urandom_range(0, 8)));
         runInstr("rand", ins, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1000);
      end

      runInstr("illegal", 32'h00000000, 1'b0, 0, 0, 1000);
      doReset();
      runInstr("fetch_timeout", 32'h00700093, 1'b0, MEM_TIMEOUT, 0, 1000);
      doReset();
      runInstr("sw_mem_timeout", 32'h007001A3, 1'b0, 1, MEM_TIMEOUT, 1000);
      doReset();
      runInstr("addi_pre", 32'h00700093, 1'b0, 0, 0, 1000);

      // Abort a LOAD partway through its memory wait with an asynchronous reset.
      runInstr("lw_abort", 32'h00002083, 1'b0, 0, 5, 5);
      mem_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_instret = 32'd0;
      checkOutput("reset_mid_mem", '0, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      runInstr("after_reset", 32'h00700093, 1'b0, 0, 0, 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
